// File: rtl/multichan_growing_avg_if.sv
// Stream interface for the multi-channel block averager: sample input side plus
// averaged output side. The master drives samples and the slave returns averages.
interface multichan_growing_avg_if #(
  parameter int W        = 16,
  parameter int NCHAN    = 4,
  parameter int MAX_LOG2 = 7
);
  localparam int CH_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int N_W  = (MAX_LOG2 > 0) ? $clog2(MAX_LOG2 + 1) : 1;

  logic [N_W-1:0]  n_avgs;
  logic            valid;
  logic [W-1:0]    x;
  logic            sof;
  logic [W-1:0]    y;
  logic            y_valid;
  logic [CH_W-1:0] y_chan;
  logic            y_last;
  logic            sync_err;

  modport master (
    output n_avgs, valid, x, sof,
    input  y, y_valid, y_chan, y_last, sync_err
  );

  modport slave (
    input  n_avgs, valid, x, sof,
    output y, y_valid, y_chan, y_last, sync_err
  );
endinterface

// File: rtl/multichan_growing_avg.sv
// Integrate-and-dump averager for a time-interleaved NCHAN stream: each channel is
// summed over 2^n frames, then one scaled average per channel is emitted.
module multichan_growing_avg #(
  parameter int W        = 16,
  parameter int NCHAN    = 4,
  parameter int MAX_LOG2 = 7,
  parameter bit SIGNED   = 1'b1,
  parameter bit ROUND    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  multichan_growing_avg_if.slave  bus
);
  localparam int CH_W  = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int N_W   = (MAX_LOG2 > 0) ? $clog2(MAX_LOG2 + 1) : 1;
  localparam int ACC_W = W + MAX_LOG2 + 1;
  localparam int FRM_W = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

  logic [CH_W-1:0]  chan_q, chan_d, cur_chan;
  logic [FRM_W-1:0] frm_q, frm_d, cur_frm;
  logic [N_W-1:0]   n_act_q, n_act_d, n_eff, n_clamp;
  logic [ACC_W-1:0] acc_q [NCHAN];
  logic [ACC_W-1:0] acc_d [NCHAN];
  logic [W-1:0]     y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [CH_W-1:0]  y_chan_q, y_chan_d;
  logic             y_last_q, y_last_d;
  logic             sync_err_q, sync_err_d;

  logic [ACC_W-1:0]        ext_x, s, rnd, sum, shifted;
  logic signed [ACC_W-1:0] sum_s;
  logic [FRM_W:0]          frm_lim;
  logic                    block_start, misalign, frm_last, chan_last;

  // NOTE: every variable written here gets a default first, so no latches are inferred.
  always_comb begin
    n_clamp     = (bus.n_avgs > N_W'(MAX_LOG2)) ? N_W'(MAX_LOG2) : bus.n_avgs;
    block_start = (chan_q == '0) && (frm_q == '0);
    misalign    = bus.valid && bus.sof && !block_start;

    // A misaligned sof restarts the block on this very sample, so it behaves as chan 0/frm 0.
    n_eff    = (block_start || misalign) ? n_clamp : n_act_q;
    cur_chan = misalign ? '0 : chan_q;
    cur_frm  = misalign ? '0 : frm_q;

    frm_lim   = ((FRM_W + 1)'(1) << n_eff) - (FRM_W + 1)'(1);
    frm_last  = ({1'b0, cur_frm} == frm_lim);
    chan_last = (cur_chan == CH_W'(NCHAN - 1));

    ext_x = SIGNED ? {{(ACC_W - W){bus.x[W-1]}}, bus.x} : {{(ACC_W - W){1'b0}}, bus.x};
    s     = (cur_frm == '0) ? ext_x : acc_q[cur_chan] + ext_x;
    rnd   = (ROUND && (n_eff != '0)) ? (ACC_W'(1) << (n_eff - N_W'(1))) : '0;
    sum   = s + rnd;
    sum_s = signed'(sum);
    if (SIGNED) shifted = sum_s >>> n_eff;
    else        shifted = sum >> n_eff;

    chan_d     = chan_q;
    frm_d      = frm_q;
    n_act_d    = n_act_q;
    acc_d      = acc_q;
    y_d        = y_q;
    y_valid_d  = 1'b0;
    y_chan_d   = y_chan_q;
    y_last_d   = y_last_q;
    sync_err_d = misalign;

    if (bus.valid) begin
      n_act_d = n_eff;
      if (frm_last) begin
        y_d       = shifted[W-1:0];
        y_valid_d = 1'b1;
        y_chan_d  = cur_chan;
        y_last_d  = chan_last;
      end else begin
        acc_d[cur_chan] = s;
      end

      if (chan_last) begin
        chan_d = '0;
        frm_d  = frm_last ? '0 : cur_frm + FRM_W'(1);
      end else begin
        chan_d = cur_chan + CH_W'(1);
        frm_d  = cur_frm;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      chan_q     <= '0;
      frm_q      <= '0;
      n_act_q    <= '0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      y_chan_q   <= '0;
      y_last_q   <= 1'b0;
      sync_err_q <= 1'b0;
      // NOTE: the accumulator array is small (NCHAN words), so clearing it in reset is cheap.
      for (int i = 0; i < NCHAN; i++) acc_q[i] <= '0;
    end else begin
      chan_q     <= chan_d;
      frm_q      <= frm_d;
      n_act_q    <= n_act_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
      y_chan_q   <= y_chan_d;
      y_last_q   <= y_last_d;
      sync_err_q <= sync_err_d;
      for (int i = 0; i < NCHAN; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign bus.y        = y_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.y_chan   = y_chan_q;
  assign bus.y_last   = y_last_q;
  assign bus.sync_err = sync_err_q;
endmodule

// File: tb/tb_multichan_growing_avg.sv
// Directed bench for multichan_growing_avg: one unsigned and two signed (floor/round)
// instances share the same stimulus; expected values are computed by hand or by a small model.
module tb_multichan_growing_avg;
  localparam int W = 16, NCHAN = 4, MAX_LOG2 = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  n_avgs = '0;
  logic        valid = 1'b0;
  logic [15:0] x = '0;
  logic        sof = 1'b0;

  always #5 clk = ~clk;

  multichan_growing_avg_if #(.W(W), .NCHAN(NCHAN), .MAX_LOG2(MAX_LOG2)) bu ();
  multichan_growing_avg_if #(.W(W), .NCHAN(NCHAN), .MAX_LOG2(MAX_LOG2)) bs0 ();
  multichan_growing_avg_if #(.W(W), .NCHAN(NCHAN), .MAX_LOG2(MAX_LOG2)) bs1 ();

  assign bu.n_avgs  = n_avgs;  assign bu.valid  = valid;  assign bu.x  = x;  assign bu.sof  = sof;
  assign bs0.n_avgs = n_avgs;  assign bs0.valid = valid;  assign bs0.x = x;  assign bs0.sof = sof;
  assign bs1.n_avgs = n_avgs;  assign bs1.valid = valid;  assign bs1.x = x;  assign bs1.sof = sof;

  multichan_growing_avg #(.W(W), .NCHAN(NCHAN), .MAX_LOG2(MAX_LOG2), .SIGNED(1'b0), .ROUND(1'b0))
    u_dut_u (.clk(clk), .rst(rst), .bus(bu.slave));
  multichan_growing_avg #(.W(W), .NCHAN(NCHAN), .MAX_LOG2(MAX_LOG2), .SIGNED(1'b1), .ROUND(1'b0))
    u_dut_s0 (.clk(clk), .rst(rst), .bus(bs0.slave));
  multichan_growing_avg #(.W(W), .NCHAN(NCHAN), .MAX_LOG2(MAX_LOG2), .SIGNED(1'b1), .ROUND(1'b1))
    u_dut_s1 (.clk(clk), .rst(rst), .bus(bs1.slave));

  typedef struct {
    logic        v;
    logic [15:0] x;
    logic        sof;
    logic [2:0]  n;
    logic        yv;
    logic [15:0] y;
    logic [1:0]  ch;
    logic        last;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function void add(input logic v, input logic [15:0] xv, input logic s, input logic [2:0] n,
                    input logic yv, input logic [15:0] y, input logic [1:0] ch,
                    input logic last, input logic err);
    vecs.push_back('{v, xv, s, n, yv, y, ch, last, err});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the falling edge; return #1 after the capturing rising edge.
  task automatic step(input logic v, input logic [15:0] xv, input logic s, input logic [2:0] n);
    @(negedge clk);
    valid  = v;
    x      = xv;
    sof    = s;
    n_avgs = n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b0;
    sof   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] mix_x(input int f, input int c);
    return 16'(f * 37 + c * 11 + 5);
  endfunction

  logic [15:0] hold_y;
  logic [1:0]  hold_ch;
  logic        hold_last;
  logic [15:0] neg_ch1 [4];
  logic [15:0] full_vals [3];
  logic [15:0] exp_avg [4];
  logic        exp_em;
  int          sum_m;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Test 1: unsigned n=1 averaging over two frames
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);      add(1, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 2, 0, 1, 0, 0, 0, 0, 0);      add(1, 3, 0, 1, 0, 0, 0, 0, 0);
    add(1, 10, 0, 1, 1, 5, 0, 0, 0);     add(1, 3, 0, 1, 1, 2, 1, 0, 0);
    add(1, 2, 0, 1, 1, 2, 2, 0, 0);      add(1, 6, 0, 1, 1, 4, 3, 1, 0);
    // n=0 passthrough, including a gap with sof asserted (ignored)
    add(1, 7, 0, 0, 1, 7, 0, 0, 0);      add(0, 16'h1234, 1, 0, 0, 0, 0, 0, 0);
    add(1, 9, 0, 0, 1, 9, 1, 0, 0);      add(1, 100, 0, 0, 1, 100, 2, 0, 0);
    add(1, 16'hFFFF, 0, 0, 1, 16'hFFFF, 3, 1, 0);
    // sof at chan 2: resync, partial block dropped
    add(1, 1, 0, 1, 0, 0, 0, 0, 0);      add(1, 2, 0, 1, 0, 0, 0, 0, 0);
    add(1, 20, 1, 1, 0, 0, 0, 0, 1);     add(1, 30, 0, 1, 0, 0, 0, 0, 0);
    add(1, 40, 0, 1, 0, 0, 0, 0, 0);     add(1, 50, 0, 1, 0, 0, 0, 0, 0);
    add(1, 22, 0, 1, 1, 21, 0, 0, 0);    add(1, 32, 0, 1, 1, 31, 1, 0, 0);
    add(1, 42, 0, 1, 1, 41, 2, 0, 0);    add(1, 52, 0, 1, 1, 51, 3, 1, 0);
    // aligned sof: no error; n_avgs 1->3 mid-block keeps n=1 for this block
    add(1, 4, 1, 1, 0, 0, 0, 0, 0);      add(1, 4, 0, 1, 0, 0, 0, 0, 0);
    add(1, 4, 0, 1, 0, 0, 0, 0, 0);      add(1, 4, 0, 1, 0, 0, 0, 0, 0);
    add(1, 6, 0, 3, 1, 5, 0, 0, 0);      add(1, 6, 0, 3, 1, 5, 1, 0, 0);
    add(1, 6, 0, 3, 1, 5, 2, 0, 0);      add(1, 6, 0, 3, 1, 5, 3, 1, 0);

    neg_ch1   = '{16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFC};
    full_vals = '{16'h7FFF, 16'hFFFF, 16'h8000};

    do_reset();
    check("rst_y", bu.y, 0);
    check("rst_y_valid", bu.y_valid, 0);
    check("rst_y_chan", bu.y_chan, 0);
    check("rst_y_last", bu.y_last, 0);
    check("rst_sync_err", bu.sync_err, 0);
    check("rst_s0_y_valid", bs0.y_valid, 0);

    hold_y = '0; hold_ch = '0; hold_last = 1'b0;
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].x, vecs[i].sof, vecs[i].n);
      if (vecs[i].yv) begin
        hold_y = vecs[i].y; hold_ch = vecs[i].ch; hold_last = vecs[i].last;
      end
      check($sformatf("vec%0d_y_valid", i), bu.y_valid, vecs[i].yv);
      check($sformatf("vec%0d_sync_err", i), bu.sync_err, vecs[i].err);
      check($sformatf("vec%0d_y", i), bu.y, hold_y);
      check($sformatf("vec%0d_y_chan", i), bu.y_chan, hold_ch);
      check($sformatf("vec%0d_y_last", i), bu.y_last, hold_last);
    end

    // Next block latched n=3: 8 frames; n_avgs drops to 1 mid-block and must be ignored
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 4; c++) begin
        step(1, 16'(10 * f + c), 0, (f == 0 && c == 0) ? 3'd3 : 3'd1);
        check($sformatf("n3_f%0d_c%0d_y_valid", f, c), bu.y_valid, f == 7);
        if (f == 7) begin
          check($sformatf("n3_c%0d_y", c), bu.y, 35 + c);
          check($sformatf("n3_c%0d_y_chan", c), bu.y_chan, c);
          check($sformatf("n3_c%0d_y_last", c), bu.y_last, c == 3);
        end
      end

    // Signed n=2: ch1 sees -3,-3,-3,-4 -> floor -4, round -3
    do_reset();
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < 4; c++) begin
        step(1, (c == 1) ? neg_ch1[f] : 16'h0000, 0, 2);
        if (f == 3) begin
          check($sformatf("sgn_c%0d_s0_y_valid", c), bs0.y_valid, 1);
          check($sformatf("sgn_c%0d_s1_y_valid", c), bs1.y_valid, 1);
          check($sformatf("sgn_c%0d_s0_y", c), bs0.y, (c == 1) ? 16'hFFFC : 16'h0000);
          check($sformatf("sgn_c%0d_s1_y", c), bs1.y, (c == 1) ? 16'hFFFD : 16'h0000);
        end else begin
          check($sformatf("sgn_f%0d_c%0d_s0_y_valid", f, c), bs0.y_valid, 0);
        end
      end

    // Full scale, n=7 (128 frames): averages must equal the constant input
    do_reset();
    for (int k = 0; k < 3; k++)
      for (int f = 0; f < 128; f++)
        for (int c = 0; c < 4; c++) begin
          step(1, full_vals[k], 0, 7);
          exp_em = (f == 127);
          check($sformatf("fs%0d_f%0d_c%0d_y_valid", k, f, c), bu.y_valid, exp_em);
          if (exp_em) begin
            check($sformatf("fs%0d_c%0d_u_y", k, c), bu.y, full_vals[k]);
            check($sformatf("fs%0d_c%0d_s0_y", k, c), bs0.y, full_vals[k]);
            check($sformatf("fs%0d_c%0d_s1_y", k, c), bs1.y, full_vals[k]);
            check($sformatf("fs%0d_c%0d_s1_y_valid", k, c), bs1.y_valid, 1);
          end
        end

    // Gap-free and randomly gapped runs of the same data against a reference average
    for (int c = 0; c < 4; c++) begin
      sum_m = 0;
      for (int f = 0; f < 4; f++) sum_m += int'(mix_x(f, c));
      exp_avg[c] = 16'(sum_m / 4);
    end
    for (int run = 0; run < 2; run++) begin
      do_reset();
      for (int f = 0; f < 4; f++)
        for (int c = 0; c < 4; c++) begin
          if (run == 1)
            repeat ($urandom_range(0, 3)) begin
              step(0, 16'hDEAD, 0, 2);
              check($sformatf("gap_idle_f%0d_c%0d_y_valid", f, c), bu.y_valid, 0);
            end
          step(1, mix_x(f, c), 0, 2);
          check($sformatf("gap%0d_f%0d_c%0d_y_valid", run, f, c), bu.y_valid, f == 3);
          if (f == 3) begin
            check($sformatf("gap%0d_c%0d_y", run, c), bu.y, exp_avg[c]);
            check($sformatf("gap%0d_c%0d_y_chan", run, c), bu.y_chan, c);
          end
        end
    end

    // Reset in frame 1 of an n=1 block, then a clean block
    do_reset();
    for (int c = 0; c < 4; c++) step(1, 100, 0, 1);
    step(1, 50, 0, 1);
    check("mid_pre_y", bu.y, 75);
    do_reset();
    check("mid_rst_y", bu.y, 0);
    check("mid_rst_y_valid", bu.y_valid, 0);
    check("mid_rst_y_chan", bu.y_chan, 0);
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 4; c++) begin
        step(1, 16'(2 * c + 2 + 2 * f), 0, 1);
        check($sformatf("mid_f%0d_c%0d_y_valid", f, c), bu.y_valid, f == 1);
        if (f == 1) begin
          check($sformatf("mid_c%0d_y", c), bu.y, 2 * c + 3);
          check($sformatf("mid_c%0d_y_chan", c), bu.y_chan, c);
        end
      end

    // n=0 latency: output exactly one cycle after the sample, then drops
    step(1, 16'hABCD, 0, 0);
    check("lat_y_valid", bu.y_valid, 1);
    check("lat_y", bu.y, 16'hABCD);
    step(0, 16'h0000, 0, 0);
    check("lat_idle_y_valid", bu.y_valid, 0);
    check("lat_hold_y", bu.y, 16'hABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
